alu_mc: RTL and testbench

- Parametrised, handshaked successor to the single-cycle 32-bit combinational ALU used by the core's execute stage.
- Adds a WIDTH parameter, registered output, and valid/ready flow control on both input and output.
- Adds multi-cycle iterative multiply and unsigned divide, so execute can stall on long operations without a combinational multiplier or divider.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_muldiv_iter.sv | 84 ++++++++
 rtl/alu_mc.sv | 149 ++++++++++++++
 tb/tb_alu_mc.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   op_e     - 4-bit opcode encoding (0..15)
//   OPB_*    - operand-B select encodings for irmux
//   state_e  - handshake FSM states
//   is_iter  - true for opcodes that use the iterative mul/div unit
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11,
    OP_BLT  = 4'd12,
    OP_BGE  = 4'd13,
    OP_MUL  = 4'd14,
    OP_DIVU = 4'd15
  } op_e;

  localparam logic [1:0] OPB_RS2  = 2'd0;
  localparam logic [1:0] OPB_IMMS = 2'd1;
  localparam logic [1:0] OPB_IMMI = 2'd2;
  localparam logic [1:0] OPB_ZERO = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative multiplier / unsigned divider, one step per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin WIDTH iterations
//   op         : opcode at start (OP_DIVU selects divide, otherwise multiply)
//   a, b       : operands
//   done       : high during the cycle in which the final iteration is taken
//   res        : final result, valid while done is high
// MUL is shift-add over the bits of b, LSB first. DIVU is restoring
// division producing one quotient bit per cycle, MSB first.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int SHW = $clog2(WIDTH);

  // Shared registers: p = accumulator / remainder,
  // x = multiplicand / dividend-then-quotient, y = multiplier / divisor.
  logic             active_q;
  logic             div_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             qbit;

  always_comb begin
    // Remainder is always below the divisor (except for a zero divisor,
    // where qbit is forced to 1 every step), so WIDTH bits hold the difference.
    rem_sh  = {p_q, x_q[WIDTH-1]};
    rem_sub = rem_sh[WIDTH-1:0] - y_q;
    qbit    = (rem_sh >= {1'b0, y_q});
    if (div_q) begin
      p_d = qbit ? rem_sub : rem_sh[WIDTH-1:0];
      x_d = {x_q[WIDTH-2:0], qbit};
      y_d = y_q;
    end else begin
      p_d = y_q[0] ? (p_q + x_q) : p_q;
      x_d = x_q << 1;
      y_d = y_q >> 1;
    end
  end

  assign done = active_q && (cnt_q == SHW'(WIDTH - 1));
  // Result is the value after the step being taken this cycle.
  assign res  = div_q ? x_d : p_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      div_q    <= 1'b0;
      cnt_q    <= '0;
      p_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      div_q    <= (op == OP_DIVU);
      cnt_q    <= '0;
      p_q      <= '0;
      x_q      <= a;
      y_q      <= b;
    end else if (active_q) begin
      p_q   <= p_d;
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_q + 1'b1;
      if (done) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU with registered result and iterative MUL/DIVU.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation offer / acceptance
//   i1, i2, imms, immi  : operand A, rs2, S-immediate, I-immediate
//   irmux               : operand-B select (rs2 / imms / immi / zero)
//   op                  : opcode (alu_pkg::op_e)
//   out_valid/out_ready : result offer / consumption
//   result, bt          : registered result and branch-taken flag
//   busy                : iterative multiply/divide in progress
module alu_mc
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] imms,
  input  logic [WIDTH-1:0] immi,
  input  logic [1:0]       irmux,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             bt,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opb;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res;
  logic             alu_bt;
  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_res;
  logic [WIDTH-1:0] result_q;
  logic             bt_q;

  always_comb begin
    case (irmux)
      OPB_RS2:  opb = i2;
      OPB_IMMS: opb = imms;
      OPB_IMMI: opb = immi;
      OPB_ZERO: opb = '0;
      default:  opb = '0;
    endcase
  end

  assign sh = opb[SHW-1:0];

  // Single-cycle operations.
  always_comb begin
    alu_res = '0;
    alu_bt  = 1'b0;
    case (op_e'(op))
      OP_ADD:  alu_res = i1 + opb;
      OP_SUB:  alu_res = i1 - opb;
      OP_AND:  alu_res = i1 & opb;
      OP_OR:   alu_res = i1 | opb;
      OP_XOR:  alu_res = i1 ^ opb;
      OP_SLL:  alu_res = i1 << sh;
      OP_SRL:  alu_res = i1 >> sh;
      OP_SRA:  alu_res = $unsigned($signed(i1) >>> sh);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(i1) < $signed(opb))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (i1 < opb)};
      OP_BEQ:  alu_bt  = (i1 == opb);
      OP_BNE:  alu_bt  = (i1 != opb);
      OP_BLT:  alu_bt  = ($signed(i1) < $signed(opb));
      OP_BGE:  alu_bt  = ($signed(i1) >= $signed(opb));
      default: alu_res = '0;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign md_start = accept && is_iter(op);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .op    (op),
    .a     (i1),
    .b     (opb),
    .done  (md_done),
    .res   (md_res)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = is_iter(op) ? BUSY : DONE;
      BUSY: if (md_done) state_d = DONE;
      DONE: begin
        if (out_ready) begin
          if (accept) state_d = is_iter(op) ? BUSY : DONE;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. In DONE, in_ready follows out_ready so a new op can be
  // taken in the same cycle the current result is consumed.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: in_ready = rst_n;
      BUSY: busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      bt_q     <= 1'b0;
    end else if (accept && !is_iter(op)) begin
      result_q <= alu_res;
      bt_q     <= alu_bt;
    end else if (md_done) begin
      result_q <= md_res;
      bt_q     <= 1'b0;
    end
  end

  assign result = result_q;
  assign bt     = bt_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 32-bit instance
  logic        in_valid, in_ready, out_valid, out_ready, bt, busy;
  logic [31:0] i1, i2, imms, immi, result;
  logic [1:0]  irmux;
  logic [3:0]  op;

  // 8-bit instance
  logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_bt, n_busy;
  logic [7:0] n_i1, n_i2, n_imms, n_immi, n_result;
  logic [1:0] n_irmux;
  logic [3:0] n_op;

  int checks   = 0;
  int failures = 0;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .i1(i1), .i2(i2), .imms(imms), .immi(immi), .irmux(irmux), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .bt(bt), .busy(busy)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .i1(n_i1), .i2(n_i2), .imms(n_imms), .immi(n_immi), .irmux(n_irmux), .op(n_op),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .result(n_result), .bt(n_bt), .busy(n_busy)
  );

  // ---------------- reference model ----------------
  function automatic longint sx(input int w, input logic [63:0] v);
    return v[w-1] ? (longint'(v) - (longint'(1) << w)) : longint'(v);
  endfunction

  function automatic logic [63:0] ref_res(input int w, input logic [3:0] fop,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m;
    int s;
    m = (64'd1 << w) - 64'd1;
    s = int'(b % 64'(w));
    case (fop)
      4'd0:  return (a + b) & m;
      4'd1:  return (a - b) & m;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return (a << s) & m;
      4'd6:  return a >> s;
      4'd7:  return 64'(sx(w, a) >>> s) & m;
      4'd8:  return (sx(w, a) < sx(w, b)) ? 64'd1 : 64'd0;
      4'd9:  return (a < b) ? 64'd1 : 64'd0;
      4'd14: return (a * b) & m;
      4'd15: return (b == 64'd0) ? m : (a / b);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic ref_bt(input int w, input logic [3:0] fop,
                                  input logic [63:0] a, input logic [63:0] b);
    case (fop)
      4'd10: return a == b;
      4'd11: return a != b;
      4'd12: return sx(w, a) <  sx(w, b);
      4'd13: return sx(w, a) >= sx(w, b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick_b(input logic [1:0] mx, input logic [31:0] r2,
                                         input logic [31:0] s, input logic [31:0] im);
    case (mx)
      2'd0: return r2;
      2'd1: return s;
      2'd2: return im;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- drivers (no checking) ----------------
  // Called near a falling edge with out_ready set by the caller. Returns at
  // the falling edge where out_valid is first seen (or on timeout, ok=0).
  task automatic exec32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b2,
                        input logic [31:0] s, input logic [31:0] im, input logic [1:0] mx,
                        output logic [31:0] r, output logic b_t, output int lat,
                        output int bcnt, output bit ok);
    int w;
    ok = 1'b1; w = 0;
    op = o; i1 = a; i2 = b2; imms = s; immi = im; irmux = mx; in_valid = 1'b1;
    #1;
    while (!in_ready) begin
      @(negedge clk); #1; w++;
      if (w > 100) begin ok = 1'b0; break; end
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    i1 = $urandom; i2 = $urandom; imms = $urandom; immi = $urandom;
    irmux = 2'($urandom); op = 4'($urandom);
    lat = 1; bcnt = 0;
    while (!out_valid && lat < 200) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) ok = 1'b0;
    r = result; b_t = bt;
    $display("txn w=32 op=%0d a=%h b=%h res=%h bt=%0b lat=%0d", o, a, pick_b(mx, b2, s, im), r, b_t, lat);
  endtask

  task automatic exec8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b2,
                       output logic [7:0] r, output int lat, output bit ok);
    int w;
    ok = 1'b1; w = 0;
    n_op = o; n_i1 = a; n_i2 = b2; n_imms = 8'($urandom); n_immi = 8'($urandom);
    n_irmux = 2'd0; n_in_valid = 1'b1;
    #1;
    while (!n_in_ready) begin
      @(negedge clk); #1; w++;
      if (w > 100) begin ok = 1'b0; break; end
    end
    @(posedge clk);
    @(negedge clk);
    n_in_valid = 1'b0;
    n_i1 = 8'($urandom); n_i2 = 8'($urandom); n_op = 4'($urandom);
    lat = 1;
    while (!n_out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!n_out_valid) ok = 1'b0;
    r = n_result;
    $display("txn w=8 op=%0d a=%h b=%h res=%h lat=%0d", o, a, b2, r, lat);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; out_ready = 1; op = 0; i1 = 0; i2 = 0; imms = 0; immi = 0; irmux = 0;
    n_in_valid = 0; n_out_ready = 1; n_op = 0; n_i1 = 0; n_i2 = 0; n_imms = 0; n_immi = 0; n_irmux = 0;
    repeat (3) @(negedge clk);
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end checks++;
    if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end checks++;
    if (bt !== 1'b0) begin failures++; $display("FAIL reset_bt got=%0b exp=0", bt); end checks++;
    if (n_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready8 got=%0b exp=0", n_in_ready); end checks++;
    rst_n = 1'b1;
    #1;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end checks++;
  endtask

  task automatic test_directed();
    logic [31:0] r; logic b_t; int lat, bc; bit ok;

    exec32(4'd0, 32'd687, 32'd1684168, 32'd0, 32'd0, 2'd0, r, b_t, lat, bc, ok);
    if (!ok) begin failures++; $display("FAIL add_timeout got=timeout exp=out_valid"); end checks++;
    if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end checks++;
    if (r !== 32'd1684855) begin failures++; $display("FAIL add_result got=%0d exp=1684855", r); end checks++;
    if (b_t !== 1'b0) begin failures++; $display("FAIL add_bt got=%0b exp=0", b_t); end checks++;

    exec32(4'd5, 32'd687, 32'd0, 32'd0, 32'd12, 2'd2, r, b_t, lat, bc, ok);
    if (r !== 32'd2813952) begin failures++; $display("FAIL sll_immi got=%0d exp=2813952", r); end checks++;

    exec32(4'd7, -32'sd4096, 32'd0, -32'sd12, 32'd0, 2'd1, r, b_t, lat, bc, ok);
    if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sra_imms got=%h exp=ffffffff", r); end checks++;

    exec32(4'd7, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 2'd3, r, b_t, lat, bc, ok);
    if (r !== 32'h8000_0000) begin failures++; $display("FAIL sra_by_zero got=%h exp=80000000", r); end checks++;

    exec32(4'd12, -32'sd5, 32'd3, 32'd0, 32'd0, 2'd0, r, b_t, lat, bc, ok);
    if (b_t !== 1'b1 || r !== 32'd0) begin failures++; $display("FAIL blt got=bt%0b/%h exp=bt1/0", b_t, r); end checks++;

    exec32(4'd13, -32'sd5, 32'd3, 32'd0, 32'd0, 2'd0, r, b_t, lat, bc, ok);
    if (b_t !== 1'b0) begin failures++; $display("FAIL bge got=%0b exp=0", b_t); end checks++;

    exec32(4'd10, 32'd7, 32'd7, 32'd0, 32'd0, 2'd0, r, b_t, lat, bc, ok);
    if (b_t !== 1'b1) begin failures++; $display("FAIL beq got=%0b exp=1", b_t); end checks++;

    exec32(4'd14, 32'd687, 32'd1684168, 32'd0, 32'd0, 2'd0, r, b_t, lat, bc, ok);
    if (bc !== 32) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=32", bc); end checks++;
    if (lat !== 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end checks++;
    if (r !== 32'd1157023416) begin failures++; $display("FAIL mul_result got=%0d exp=1157023416", r); end checks++;

    exec32(4'd15, 32'd1684168, 32'd687, 32'd0, 32'd0, 2'd0, r, b_t, lat, bc, ok);
    if (r !== 32'd2451 || lat !== 33) begin failures++; $display("FAIL divu got=%0d lat=%0d exp=2451 lat=33", r, lat); end checks++;

    exec32(4'd15, 32'd1234, 32'd0, 32'd0, 32'd0, 2'd0, r, b_t, lat, bc, ok);
    if (r !== 32'hFFFF_FFFF || lat !== 33) begin failures++; $display("FAIL divu_zero got=%h lat=%0d exp=ffffffff lat=33", r, lat); end checks++;

    exec32(4'd14, 32'd12345, 32'd0, 32'd0, 32'd0, 2'd3, r, b_t, lat, bc, ok);
    if (r !== 32'd0 || lat !== 33) begin failures++; $display("FAIL mul_zero got=%0d lat=%0d exp=0 lat=33", r, lat); end checks++;
  endtask

  task automatic test_random();
    logic [31:0] a, b2, s, im, bsel, r, er; logic [1:0] mx; logic [3:0] o;
    logic b_t, eb; int lat, bc, el; bit ok;
    for (int n = 0; n < 80; n++) begin
      o = 4'($urandom); a = $urandom; b2 = $urandom; s = $urandom; im = $urandom;
      mx = 2'($urandom);
      if ($urandom_range(0, 3) == 0) b2 = a;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 300));
      bsel = pick_b(mx, b2, s, im);
      er = 32'(ref_res(32, o, {32'd0, a}, {32'd0, bsel}));
      eb = ref_bt(32, o, {32'd0, a}, {32'd0, bsel});
      el = (o >= 4'd14) ? 33 : 1;
      exec32(o, a, b2, s, im, mx, r, b_t, lat, bc, ok);
      if (r !== er || b_t !== eb) begin
        failures++;
        $display("FAIL rand_op%0d got=%h/bt%0b exp=%h/bt%0b", o, r, b_t, er, eb);
      end
      checks++;
      if (lat !== el) begin failures++; $display("FAIL rand_latency op%0d got=%0d exp=%0d", o, lat, el); end checks++;
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b2;
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = $urandom; b2 = $urandom;
      op = 4'd0; i1 = a; i2 = b2; irmux = 2'd0; in_valid = 1'b1;
      #1;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready k=%0d got=%0b exp=1", k, in_ready); end checks++;
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== a + b2) begin
        failures++;
        $display("FAIL b2b_result k=%0d got=v%0b/%h exp=v1/%h", k, out_valid, result, a + b2);
      end
      checks++;
      $display("txn b2b k=%0d res=%h", k, result);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] r, a, b2; logic b_t; int lat, bc; bit ok;
    out_ready = 1'b0;
    exec32(4'd11, 32'd1, 32'd2, 32'd0, 32'd0, 2'd0, r, b_t, lat, bc, ok);
    if (!ok || b_t !== 1'b1) begin failures++; $display("FAIL bp_first got=ok%0b/bt%0b exp=ok1/bt1", ok, b_t); end checks++;
    a = $urandom; b2 = $urandom;
    op = 4'd1; i1 = a; i2 = b2; irmux = 2'd0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (out_valid !== 1'b1 || result !== 32'd0 || bt !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold c=%0d got=v%0b/%h/bt%0b/rdy%0b exp=v1/0/bt1/rdy0", c, out_valid, result, bt, in_ready);
      end
      checks++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end checks++;
    @(negedge clk);
    in_valid = 1'b0;
    if (out_valid !== 1'b1 || result !== a - b2 || bt !== 1'b0) begin
      failures++;
      $display("FAIL bp_second got=v%0b/%h/bt%0b exp=v1/%h/bt0", out_valid, result, bt, a - b2);
    end
    checks++;
    $display("txn bp second res=%h", result);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] r; logic b_t; int lat, bc; bit ok, stray;
    out_ready = 1'b1;
    op = 4'd14; i1 = 32'd1000; i2 = 32'd3000; irmux = 2'd0; in_valid = 1'b1;
    #1;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rmul_in_ready got=%0b exp=1", in_ready); end checks++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    if (busy !== 1'b1) begin failures++; $display("FAIL rmul_busy_before got=%0b exp=1", busy); end checks++;
    rst_n = 1'b0;
    #1;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rmul_in_reset got=busy%0b/v%0b/rdy%0b exp=0/0/0", busy, out_valid, in_ready);
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid || busy) stray = 1'b1;
    end
    if (stray !== 1'b0) begin failures++; $display("FAIL rmul_abandoned got=stray_output exp=none"); end checks++;
    exec32(4'd0, 32'd5, 32'd6, 32'd0, 32'd0, 2'd0, r, b_t, lat, bc, ok);
    if (r !== 32'd11 || lat !== 1) begin failures++; $display("FAIL rmul_add_after got=%0d lat=%0d exp=11 lat=1", r, lat); end checks++;
  endtask

  task automatic test_width8();
    logic [7:0] r, a, b2, er; logic [3:0] o; int lat, el; bit ok;
    exec8(4'd14, 8'd15, 8'd17, r, lat, ok);
    if (r !== 8'd255 || lat !== 9) begin failures++; $display("FAIL w8_mul got=%0d lat=%0d exp=255 lat=9", r, lat); end checks++;
    exec8(4'd1, 8'd0, 8'd1, r, lat, ok);
    if (r !== 8'hFF || lat !== 1) begin failures++; $display("FAIL w8_sub got=%h lat=%0d exp=ff lat=1", r, lat); end checks++;
    for (int n = 0; n < 30; n++) begin
      o = 4'($urandom); a = 8'($urandom); b2 = 8'($urandom);
      if (o == 4'd13 || o >= 4'd10) o = 4'($urandom_range(0, 9)) + ((n % 3 == 0) ? 4'd5 : 4'd0);
      er = 8'(ref_res(8, o, {56'd0, a}, {56'd0, b2}));
      el = (o >= 4'd14) ? 9 : 1;
      exec8(o, a, b2, r, lat, ok);
      if (r !== er || lat !== el) begin
        failures++;
        $display("FAIL w8_rand_op%0d got=%h lat=%0d exp=%h lat=%0d", o, r, lat, er, el);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
